// File: rtl/alu_pkg.sv
// Shared ALU definitions: func encodings and their 3-bit typedef, used by the ALU and by decoders.
package alu_pkg;

  typedef enum logic [2:0] {
    RA   = 3'd0,
    RB   = 3'd1,
    RADD = 3'd2,
    RSUB = 3'd3,
    RAND = 3'd4,
    ROR  = 3'd5,
    RXOR = 3'd6,
    RMUL = 3'd7
  } func_t;

  localparam int FLAG_W = 3;  // {NF, CF, ZF}

endpackage

// File: rtl/alu_frac_mul.sv
// Fractional multiply: a is a signed N-bit integer, b is signed Q1.(N-1).
// p = (a*b) >>> (N-1) over the full 2N-bit product; overflow wraps silently.
module alu_frac_mul #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] p
);

  logic signed [2*N-1:0] prod;
  logic                  unused_bits;

  assign prod = $signed(a) * $signed(b);
  // Taking product[2N-2:N-1] is the floor shift by N-1; the sign bit and fraction LSBs are dropped.
  assign p           = prod[2*N-2:N-1];
  assign unused_bits = ^{prod[2*N-1], prod[N-2:0]};

endmodule

// File: rtl/alu.sv
// Combinational N-bit ALU with registered {NF,CF,ZF} flags.
// Define ALU_MUL_EN to build the RMUL fractional multiplier; otherwise RMUL yields zero.
module alu
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      a,
  input  logic [N-1:0]      b,
  input  logic [2:0]        func,
  output logic [N-1:0]      result,
  output logic              ZF,
  output logic              NF,
  output logic              CF,
  output logic [FLAG_W-1:0] flags_q
);

  logic [N-1:0] mul_p;
  logic [N:0]   sum_ext;

`ifdef ALU_MUL_EN
  alu_frac_mul #(.N(N)) u_frac_mul (
    .a (a),
    .b (b),
    .p (mul_p)
  );
`else
  assign mul_p = '0;
`endif

  assign sum_ext = {1'b0, a} + {1'b0, b};

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    result = '0;
    CF     = 1'b0;
    unique case (func_t'(func))
      RA:   result = a;
      RB:   result = b;
      RADD: begin
        result = sum_ext[N-1:0];
        CF     = sum_ext[N];
      end
      RSUB: begin
        result = a - b;
        CF     = (a < b);
      end
      RAND: result = a & b;
      ROR:  result = a | b;
      RXOR: result = a ^ b;
      RMUL: result = mul_p;
      default: result = '0;
    endcase
  end

  assign ZF = (result == '0);
  assign NF = result[N-1];

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) flags_q <= '0;
    else        flags_q <= {NF, CF, ZF};
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu (N=8): vector table, random model checks, and reset sequences;
// flags_q expectations go through a scoreboard queue.
module tb_alu;
  import alu_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] a, b;
  logic [2:0]   func;
  logic [N-1:0] result;
  logic         ZF, NF, CF;
  logic [2:0]   flags_q;

  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] sb_q[$];

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    func_t        f;
    logic [N-1:0] res;
    logic         zf;
    logic         nf;
    logic         cf;
  } vec_t;

  vec_t vecs[$];

  alu #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .func    (func),
    .result  (result),
    .ZF      (ZF),
    .NF      (NF),
    .CF      (CF),
    .flags_q (flags_q)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Independent reference: 16-bit signed product shifted arithmetically, low byte kept.
  task automatic model(input logic [N-1:0] ma, input logic [N-1:0] mb, input func_t mf,
                       output logic [N-1:0] mres, output logic mcf);
    int ia, ib, ip;
    mcf = 1'b0;
    case (mf)
      RA:   mres = ma;
      RB:   mres = mb;
      RADD: begin
        ip   = int'(ma) + int'(mb);
        mres = ip[N-1:0];
        mcf  = (ip > 255);
      end
      RSUB: begin
        ip   = int'(ma) - int'(mb);
        mres = ip[N-1:0];
        mcf  = (ip < 0);
      end
      RAND: mres = ma & mb;
      ROR:  mres = ma | mb;
      RXOR: mres = ma ^ mb;
      default: begin
`ifdef ALU_MUL_EN
        ia   = int'($signed(ma));
        ib   = int'($signed(mb));
        ip   = (ia * ib) >>> (N - 1);
        mres = ip[N-1:0];
`else
        mres = '0;
`endif
      end
    endcase
  endtask

  // Drive one operation, check combinational outputs, then check flags_q after the edge.
  task automatic apply(input string tag, input logic [N-1:0] va, input logic [N-1:0] vb,
                       input func_t vf, input logic [N-1:0] eres, input logic ezf,
                       input logic enf, input logic ecf);
    logic [2:0] exp_flags;
    a    = va;
    b    = vb;
    func = vf;
    #1;
    check({tag, " result"}, 32'(result), 32'(eres));
    check({tag, " ZF"}, 32'(ZF), 32'(ezf));
    check({tag, " NF"}, 32'(NF), 32'(enf));
    check({tag, " CF"}, 32'(CF), 32'(ecf));
    sb_q.push_back(rst_n ? {enf, ecf, ezf} : 3'b000);
    @(posedge clk);
    #1;
    exp_flags = sb_q.pop_front();
    check({tag, " flags_q"}, 32'(flags_q), 32'(exp_flags));
  endtask

  initial begin
    logic [N-1:0] r;
    logic         c;
    vec_t         v;

    rst_n = 1'b0;
    a = '0; b = '0; func = 3'd0;
    @(posedge clk);
    #1;
    check("reset flags_q", 32'(flags_q), 32'd0);
    rst_n = 1'b1;

    vecs.push_back('{8'd5, 8'd17, RA,   8'd5,    1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'd5, 8'd17, RB,   8'd17,   1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'd5, 8'd17, RADD, 8'd22,   1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'd5, 8'd17, RSUB, 8'hF4,   1'b0, 1'b1, 1'b1});
    vecs.push_back('{8'd5, 8'd17, RAND, 8'd1,    1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'd5, 8'd17, ROR,  8'd21,   1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'd5, 8'd17, RXOR, 8'd20,   1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'hE0, 8'hE0, RSUB, 8'h00,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, RADD, 8'h00,  1'b1, 1'b0, 1'b1});
    vecs.push_back('{8'h00, 8'h01, RSUB, 8'hFF,  1'b0, 1'b1, 1'b1});
    vecs.push_back('{8'h80, 8'h80, RADD, 8'h00,  1'b1, 1'b0, 1'b1});
    vecs.push_back('{8'hF0, 8'h0F, RAND, 8'h00,  1'b1, 1'b0, 1'b0});
`ifdef ALU_MUL_EN
    vecs.push_back('{8'd20, 8'hE0, RMUL, 8'hFB,  1'b0, 1'b1, 1'b0});
    vecs.push_back('{8'h80, 8'h80, RMUL, 8'h80,  1'b0, 1'b1, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, RMUL, 8'hFF,  1'b0, 1'b1, 1'b0});
    vecs.push_back('{8'd64, 8'h40, RMUL, 8'd32,  1'b0, 1'b0, 1'b0});
`else
    vecs.push_back('{8'd20, 8'hE0, RMUL, 8'h00,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'hFF, 8'hFF, RMUL, 8'h00,  1'b1, 1'b0, 1'b0});
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      apply($sformatf("vec%0d", i), v.a, v.b, v.f, v.res, v.zf, v.nf, v.cf);
    end

    for (int i = 0; i < 40; i++) begin
      v.a = N'($urandom_range(0, 255));
      v.b = N'($urandom_range(0, 255));
      v.f = func_t'($urandom_range(0, 7));
      model(v.a, v.b, v.f, r, c);
      apply($sformatf("rnd%0d", i), v.a, v.b, v.f, r, (r == '0), r[N-1], c);
    end

    // Mid-cycle reset assertion must not disturb flags_q until the next edge.
    apply("preload", 8'hFF, 8'h01, RADD, 8'h00, 1'b1, 1'b0, 1'b1);
    a = 8'hE0; b = 8'hE0; func = RSUB;
    rst_n = 1'b0;
    #2;
    check("async-hold flags_q", 32'(flags_q), 32'b011);
    check("reset ZF live", 32'(ZF), 32'd1);
    check("reset result live", 32'(result), 32'd0);
    @(posedge clk);
    #1;
    check("reset edge flags_q", 32'(flags_q), 32'b000);
    check("reset ZF held", 32'(ZF), 32'd1);
    @(posedge clk);
    #1;
    check("reset hold flags_q", 32'(flags_q), 32'b000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset flags_q", 32'(flags_q), 32'b001);

    // Reset priority over a load that would set NF and CF.
    rst_n = 1'b0;
    apply("rst-prio", 8'h00, 8'h01, RSUB, 8'hFF, 1'b0, 1'b1, 1'b1);
    rst_n = 1'b1;

    check("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
